// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control                                                       |
// | Instruction sequencer for the multicycle CPU: drives datapath enables    |
// | and mux selects from the current state and the IR opcode field.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_control (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic [1:0] PCSrc,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       DataMemRW,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] c_OP_ADD  = 6'b000000;
  localparam logic [5:0] c_OP_SUB  = 6'b000001;
  localparam logic [5:0] c_OP_ADDI = 6'b000010;
  localparam logic [5:0] c_OP_AND  = 6'b010001;
  localparam logic [5:0] c_OP_ORI  = 6'b010010;
  localparam logic [5:0] c_OP_SW   = 6'b110000;
  localparam logic [5:0] c_OP_LW   = 6'b110001;
  localparam logic [5:0] c_OP_BEQ  = 6'b110100;
  localparam logic [5:0] c_OP_J    = 6'b111000;
  localparam logic [5:0] c_OP_JR   = 6'b111001;
  localparam logic [5:0] c_OP_JAL  = 6'b111010;
  localparam logic [5:0] c_OP_HALT = 6'b111111;

  state_t r_state;

  logic w_add, w_sub, w_addi, w_and, w_ori, w_sw, w_lw, w_beq;
  logic w_j, w_jr, w_jal, w_halt, w_alu, w_nop;

  assign w_add  = (opcode == c_OP_ADD);
  assign w_sub  = (opcode == c_OP_SUB);
  assign w_addi = (opcode == c_OP_ADDI);
  assign w_and  = (opcode == c_OP_AND);
  assign w_ori  = (opcode == c_OP_ORI);
  assign w_sw   = (opcode == c_OP_SW);
  assign w_lw   = (opcode == c_OP_LW);
  assign w_beq  = (opcode == c_OP_BEQ);
  assign w_j    = (opcode == c_OP_J);
  assign w_jr   = (opcode == c_OP_JR);
  assign w_jal  = (opcode == c_OP_JAL);
  assign w_halt = (opcode == c_OP_HALT);
  assign w_alu  = w_add | w_sub | w_addi | w_and | w_ori;
  assign w_nop  = ~(w_alu | w_sw | w_lw | w_beq | w_j | w_jr | w_jal | w_halt);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IF;
    end else begin
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          if (w_alu)             r_state <= S_EXE_AL;
          else if (w_sw || w_lw) r_state <= S_EXE_LS;
          else if (w_beq)        r_state <= S_EXE_BR;
          else if (w_halt)       r_state <= S_ID;
          else                   r_state <= S_IF;
        end
        S_EXE_AL: r_state <= S_WB_AL;
        S_WB_AL:  r_state <= S_IF;
        S_EXE_LS: r_state <= S_MEM;
        // Anything but lw (including an illegal mid-instruction change) retires here
        S_MEM:    r_state <= w_lw ? S_WB_LD : S_IF;
        S_WB_LD:  r_state <= S_IF;
        S_EXE_BR: r_state <= S_IF;
        default:  r_state <= S_IF;
      endcase
    end
  end

  assign state = r_state;

  // Outputs are gated by RST so no write strobe survives an asserted reset
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    PCSrc     = 2'b00;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    ExtSel    = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    DataMemRW = 1'b0;
    if (RST) begin
      ALUSrcB   = w_addi | w_ori | w_lw | w_sw;
      ExtSel    = ~w_ori;
      WrRegDSrc = ~w_jal;
      if (w_addi || w_ori || w_lw)      RegDst = 2'b01;
      else if (w_add || w_sub || w_and) RegDst = 2'b10;
      if (w_sub || w_beq) ALUOp = 3'b001;
      else if (w_ori)     ALUOp = 3'b011;
      else if (w_and)     ALUOp = 3'b100;
      case (r_state)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          PCWre  = w_j | w_jr | w_jal | w_nop;
          RegWre = w_jal;
          if (w_j || w_jal) PCSrc = 2'b11;
          else if (w_jr)    PCSrc = 2'b10;
        end
        S_MEM: begin
          PCWre     = ~w_lw;
          DataMemRW = w_sw;
          DBDataSrc = w_lw;
        end
        S_WB_LD: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          DBDataSrc = w_lw;
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = zero ? 2'b01 : 2'b00;
        end
        S_WB_AL: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle CPU. A registered Moore/Mealy state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives every write enable and mux select in the datapath, including the `PCWre` strobe of the program counter, which samples on the falling edge of `CLK`. One instance sits between the instruction register's opcode field and the datapath.

## Interface
- No parameters.
- `CLK`  in  1  system clock; state register updates on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction bits [31:26] from the IR.
- `zero`  in  1  ALU zero flag.
- `PCWre`  out  1  PC write enable.
- `IRWre`  out  1  instruction register write enable.
- `PCSrc`  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- `ALUSrcB`  out  1  0 register B, 1 extended immediate.
- `ALUOp`  out  3  000 add, 001 sub, 011 or, 100 and.
- `ExtSel`  out  1  0 zero-extend, 1 sign-extend.
- `RegWre`  out  1  register file write enable.
- `RegDst`  out  2  00 $31, 01 rt, 10 rd.
- `WrRegDSrc`  out  1  0 PC+4, 1 result bus.
- `DBDataSrc`  out  1  0 ALU result, 1 data memory.
- `DataMemRW`  out  1  0 read, 1 write.
- `state`  out  3  current state, for debug.

## Operation
- Opcodes:
  - ALU class: add 000000, sub 000001, addi 000010, and 010001, ori 010010.
  - Memory: sw 110000, lw 110001.
  - Control flow: beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
  - Any other opcode is a nop.
- States:
  - IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions:
  - IF→ID always.
  - ID: ALU class→EXE_AL; sw/lw→EXE_LS; beq→EXE_BR; j/jr/jal/nop→IF; halt→ID (stays).
  - EXE_AL→WB_AL→IF.
  - EXE_LS→MEM.
  - MEM: lw→WB_LD; sw→IF.
  - WB_LD→IF.
  - EXE_BR→IF.
- `opcode` is held stable by the IR after IF. The FSM decodes it combinationally in every state after IF.
- `PCWre`=1 only in the final state of an instruction (the state whose next state is IF). Specifically:
  - ID for j/jr/jal/nop;
  - WB_AL;
  - MEM for sw;
  - WB_LD;
  - EXE_BR.
  - Never for halt.
- `IRWre`=1 only in IF.
- `PCSrc`:
  - 11 in ID for j/jal;
  - 10 in ID for jr;
  - 01 in EXE_BR when `zero`=1;
  - 00 otherwise.
- `RegWre`=1 only in WB_AL, WB_LD, and ID for jal.
- `RegDst`:
  - 00 for jal;
  - 01 for addi/ori/lw;
  - 10 for add/sub/and.
- `WrRegDSrc`=0 only for jal.
- `ALUSrcB`=1 for addi, ori, lw, sw. `ExtSel`=0 only for ori.
- `ALUOp`:
  - sub for beq and sub;
  - or for ori;
  - and for and;
  - add otherwise.
- `DBDataSrc`=1 for lw in MEM and WB_LD.
- `DataMemRW`=1 only in MEM for sw.
- Non-enable selects hold their decoded values across all states of an instruction. Enables are zero outside their named states.

## Timing
- Reset (`RST`=0), asynchronous:
  - `state`=IF immediately.
  - `PCWre`, `IRWre`, `RegWre`, `DataMemRW` are forced 0 for as long as `RST`=0.
  - All other outputs are 0.
- After release, the first rising edge leaves IF.
- All outputs are combinational from `state`, `opcode` and `zero`. They settle within the first half-cycle, so the PC samples a stable `PCWre`/`PCSrc` on the falling edge.
- Instruction length in cycles:
  - j/jr/jal/nop: 2;
  - beq: 3;
  - ALU class and sw: 4;
  - lw: 5;
  - halt never completes.
- Reset mid-instruction aborts it. No partial write completes after `RST` falls.
- An opcode change outside IF is illegal; the FSM still decodes the current value without error.

## Test plan
- Reset: assert `RST`=0 mid-WB_AL. Require `state`=000 and all enables 0 asynchronously. After release: IF, then ID on the next edge.
- add (000000): state sequence 000,001,110,111,000.
  - `PCWre`=1 only in the WB_AL cycle, with `RegWre`=1, `RegDst`=10, `ALUOp`=000.
- lw then sw: lw visits 000,001,010,011,100 (5 cycles).
  - WB_LD: `DBDataSrc`=1, `RegDst`=01, `RegWre`=1.
  - sw MEM: `DataMemRW`=1, `PCWre`=1, `RegWre`=0.
- beq taken/not taken: EXE_BR with `zero`=1 gives `PCSrc`=01; with `zero`=0 gives 00. Both give `PCWre`=1 and `ALUOp`=001.
- jal (111010) in ID: `PCSrc`=11, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0, `PCWre`=1, next state IF.
- halt (111111): `state` stays 001 for 20 cycles with `PCWre`=0 throughout. Undefined opcode 101010: 2-cycle nop with `PCSrc`=00.
